// File: rtl/lvds_video_pkg.sv
// lvds_video_pkg: 7:1 LVDS pixel word bit map, default counter width and lock states,
// shared by the receive and transmit video timing blocks.
package lvds_video_pkg;
  localparam int CNT_W_DEF = 11;
  localparam int WORD_W = 21;
  localparam int R_IDX [6] = '{6, 5, 4, 3, 2, 1};
  localparam int G_IDX [6] = '{0, 13, 12, 11, 10, 9};
  localparam int B_IDX [6] = '{8, 7, 20, 19, 18, 17};
  localparam int HS_IDX = 16;
  localparam int VS_IDX = 15;
  localparam int DE_IDX = 14;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_e;
endpackage

// File: rtl/lvds_video_unpack.sv
// lvds_video_unpack: stage-1 register of the bit-mapped colour and sync fields.
module lvds_video_unpack
  import lvds_video_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] video_word,
  output logic [5:0]        r,
  output logic [5:0]        g,
  output logic [5:0]        b,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic              vld
);
  logic [5:0] r_d, g_d, b_d, r_q, g_q, b_q;
  logic hs_d, vs_d, de_d, vld_d, hs_q, vs_q, de_q, vld_q;
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    for (int i = 0; i < 6; i++) begin
      r_d[i] = video_word[R_IDX[i]];
      g_d[i] = video_word[G_IDX[i]];
      b_d[i] = video_word[B_IDX[i]];
    end
    hs_d = video_word[HS_IDX];
    vs_d = video_word[VS_IDX];
    de_d = video_word[DE_IDX];
    vld_d = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r_q, g_q, b_q} <= '0;
      {hs_q, vs_q, de_q, vld_q} <= 4'b1100;
    end else begin
      {r_q, g_q, b_q} <= {r_d, g_d, b_d};
      {hs_q, vs_q, de_q, vld_q} <= {hs_d, vs_d, de_d, vld_d};
    end
  assign {r, g, b} = {r_q, g_q, b_q};
  assign {hs, vs, de, vld} = {hs_q, vs_q, de_q, vld_q};
endmodule

// File: rtl/lvds_video_timing_rx.sv
// lvds_video_timing_rx: unpacks LVDS pixel words, tracks active-area position,
// measures line/frame timing and locks once the timing repeats.
module lvds_video_timing_rx
  import lvds_video_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] video_word,
  output logic [5:0]        pix_r,
  output logic [5:0]        pix_g,
  output logic [5:0]        pix_b,
  output logic              pix_hs,
  output logic              pix_vs,
  output logic              pix_de,
  output logic [CNT_W-1:0]  pos_x,
  output logic [CNT_W-1:0]  pos_y,
  output logic [CNT_W-1:0]  line_width,
  output logic [CNT_W-1:0]  line_total,
  output logic [CNT_W-1:0]  frame_height,
  output logic              frame_start,
  output logic              locked,
  output logic              timing_err
);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t inc(input cnt_t v);
    return &v ? v : v + 1'b1;
  endfunction
  logic [5:0] s1_r, s1_g, s1_b, pix_r_d, pix_g_d, pix_b_d, pix_r_q, pix_g_q, pix_b_q;
  logic s1_hs, s1_vs, s1_de, s1_vld;
  logic pix_hs_d, pix_vs_d, pix_de_d, pix_hs_q, pix_vs_q, pix_de_q;
  logic hs_p_d, vs_p_d, de_p_d, hs_p_q, vs_p_q, de_p_q;
  logic hs_seen_d, vs_seen_d, hs_seen_q, vs_seen_q;
  logic frame_start_d, frame_start_q, timing_err_d, timing_err_q;
  logic de_rise, de_fall, hs_fall, vs_fall, bad_w, bad_t, bad_h;
  cnt_t pos_x_d, pos_y_d, de_cnt_d, hs_cnt_d, ln_cnt_d, pos_x_q, pos_y_q, de_cnt_q, hs_cnt_q, ln_cnt_q;
  cnt_t line_width_d, line_total_d, frame_height_d, line_width_q, line_total_q, frame_height_q;
  cnt_t snap_w_d, snap_t_d, snap_h_d, snap_w_q, snap_t_q, snap_h_q;
  logic [MW-1:0] match_cnt_d, match_cnt_q;
  lock_state_e state_d, state_q;
  lvds_video_unpack u_unpack (
    .clk(clk), .rst(rst), .video_word(video_word),
    .r(s1_r), .g(s1_g), .b(s1_b), .hs(s1_hs), .vs(s1_vs), .de(s1_de), .vld(s1_vld)
  );
  // edge history only follows real stage-1 words, so no edge is seen out of reset
  assign de_rise = s1_de & ~de_p_q;
  assign de_fall = ~s1_de & de_p_q;
  assign hs_fall = ~s1_hs & hs_p_q;
  assign vs_fall = ~s1_vs & vs_p_q;
  always_comb begin
    {pix_r_d, pix_g_d, pix_b_d} = {s1_r, s1_g, s1_b};
    {pix_hs_d, pix_vs_d, pix_de_d} = {s1_hs, s1_vs, s1_de};
    {hs_p_d, vs_p_d, de_p_d} = s1_vld ? {s1_hs, s1_vs, s1_de} : {hs_p_q, vs_p_q, de_p_q};
    pos_x_d = s1_de ? (de_rise ? '0 : inc(pos_x_q)) : pos_x_q;
    pos_y_d = vs_fall ? '0 : de_fall ? inc(pos_y_q) : pos_y_q;
    de_cnt_d = s1_de ? (de_rise ? cnt_t'(1) : inc(de_cnt_q)) : de_cnt_q;
    hs_cnt_d = hs_fall ? cnt_t'(1) : inc(hs_cnt_q);
    ln_cnt_d = vs_fall ? '0 : de_fall ? inc(ln_cnt_q) : ln_cnt_q;
    hs_seen_d = hs_seen_q | hs_fall;
    vs_seen_d = vs_seen_q | vs_fall;
    line_width_d = de_fall ? de_cnt_q : line_width_q;
    line_total_d = (hs_fall && hs_seen_q) ? hs_cnt_q : line_total_q;
    // a run ending on the VS fall belongs to the frame being closed
    frame_height_d = (vs_fall && vs_seen_q) ? (de_fall ? inc(ln_cnt_q) : ln_cnt_q) : frame_height_q;
    bad_w = (line_width_d != snap_w_q) || (&line_width_d);
    bad_t = (line_total_d != snap_t_q) || (&line_total_d);
    bad_h = (frame_height_d != snap_h_q) || (&frame_height_d);
    timing_err_d = (state_q == LOCKED) &&
                   ((de_fall && bad_w) || (hs_fall && hs_seen_q && bad_t) || (vs_fall && vs_seen_q && bad_h));
    frame_start_d = vs_fall;
  end
  always_comb begin
    state_d = state_q;
    match_cnt_d = match_cnt_q;
    {snap_w_d, snap_t_d, snap_h_d} = {snap_w_q, snap_t_q, snap_h_q};
    case (state_q)
      SEARCH: if (vs_fall) begin
        state_d = TRACK;
        match_cnt_d = '0;
        {snap_w_d, snap_t_d, snap_h_d} = '0;
      end
      TRACK: if (vs_fall) begin
        if (bad_w || bad_t || bad_h) begin
          match_cnt_d = '0;
          {snap_w_d, snap_t_d, snap_h_d} = {line_width_d, line_total_d, frame_height_d};
        end else begin
          match_cnt_d = match_cnt_q + 1'b1;
          if (match_cnt_d == MW'(LOCK_FRAMES)) state_d = LOCKED;
        end
      end
      LOCKED: if (timing_err_d) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {pix_r_q, pix_g_q, pix_b_q} <= '0;
      {pix_hs_q, pix_vs_q, pix_de_q} <= 3'b110;
      {hs_p_q, vs_p_q, de_p_q, hs_seen_q, vs_seen_q} <= '0;
      {pos_x_q, pos_y_q, de_cnt_q, hs_cnt_q, ln_cnt_q} <= '0;
      {line_width_q, line_total_q, frame_height_q} <= '0;
      {snap_w_q, snap_t_q, snap_h_q} <= '0;
      match_cnt_q <= '0;
      state_q <= SEARCH;
      {frame_start_q, timing_err_q} <= '0;
    end else begin
      {pix_r_q, pix_g_q, pix_b_q} <= {pix_r_d, pix_g_d, pix_b_d};
      {pix_hs_q, pix_vs_q, pix_de_q} <= {pix_hs_d, pix_vs_d, pix_de_d};
      {hs_p_q, vs_p_q, de_p_q, hs_seen_q, vs_seen_q} <= {hs_p_d, vs_p_d, de_p_d, hs_seen_d, vs_seen_d};
      {pos_x_q, pos_y_q, de_cnt_q, hs_cnt_q, ln_cnt_q} <= {pos_x_d, pos_y_d, de_cnt_d, hs_cnt_d, ln_cnt_d};
      {line_width_q, line_total_q, frame_height_q} <= {line_width_d, line_total_d, frame_height_d};
      {snap_w_q, snap_t_q, snap_h_q} <= {snap_w_d, snap_t_d, snap_h_d};
      match_cnt_q <= match_cnt_d;
      state_q <= state_d;
      {frame_start_q, timing_err_q} <= {frame_start_d, timing_err_d};
    end
  assign {pix_r, pix_g, pix_b} = {pix_r_q, pix_g_q, pix_b_q};
  assign {pix_hs, pix_vs, pix_de} = {pix_hs_q, pix_vs_q, pix_de_q};
  assign {pos_x, pos_y} = {pos_x_q, pos_y_q};
  assign {line_width, line_total, frame_height} = {line_width_q, line_total_q, frame_height_q};
  assign {frame_start, timing_err} = {frame_start_q, timing_err_q};
  assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_lvds_video_timing_rx.sv
// tb_lvds_video_timing_rx: directed checks of unpacking, position, measurement and lock behaviour
// on a reduced raster (16 active + 6 blank clk per line, 8 active + 3 blank lines per frame).
module tb_lvds_video_timing_rx;
  localparam int W = 16, HB = 6, T = W + HB, H = 8, VB = 3, FL = (H + VB) * T;
  localparam int NV = (H + 1) * T;
  localparam int CV = (H - 1) * T + W;
  logic clk = 0, rst = 1;
  logic [20:0] vw = '0;
  logic [5:0] pix_r, pix_g, pix_b;
  logic pix_hs, pix_vs, pix_de, frame_start, locked, timing_err;
  logic [10:0] pos_x, pos_y, line_width, line_total, frame_height;
  int tests = 0, fails = 0;
  int fs_cnt = 0, err_cnt = 0, lock_fs = -1, err_fs = -1;
  int base;
  logic [10:0] first_x = '1, first_y = '1, last_x = '0, last_y = '0, done_x = '0, done_y = '0, fs_pos_y = '1;
  logic arm = 0, lk_prev = 0, err_locked = 1;

  lvds_video_timing_rx dut (
    .clk(clk), .rst(rst), .video_word(vw),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de),
    .pos_x(pos_x), .pos_y(pos_y),
    .line_width(line_width), .line_total(line_total), .frame_height(frame_height),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt++;
      fs_pos_y = pos_y;
      done_x = last_x;
      done_y = last_y;
      arm = 1;
    end
    if (pix_de) begin
      last_x = pos_x;
      last_y = pos_y;
      if (arm) begin
        first_x = pos_x;
        first_y = pos_y;
        arm = 0;
      end
    end
    if (timing_err) begin
      err_cnt++;
      err_fs = fs_cnt;
      err_locked = locked;
    end
    if (locked && !lk_prev) lock_fs = fs_cnt;
    lk_prev = locked;
  end

  function automatic logic [20:0] mk(input int f, input int vs0, input int sl);
    int ln, x;
    logic [20:0] w;
    ln = f / T;
    x = f % T;
    w = '0;
    w[14] = (ln < H) && (x < ((ln == sl) ? W - 1 : W));
    w[16] = !((x >= W + 2) && (x < W + 4));
    w[15] = !((f >= vs0) && (f < vs0 + T));
    return w;
  endfunction

  task automatic drive(input int vs0, input int sl, input int f0, input int f1);
    for (int f = f0; f < f1; f++) begin
      @(negedge clk);
      vw = mk(f, vs0, sl);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sync", {pix_hs, pix_vs, pix_de}, 3'b110);
    chk("rst_pix", {pix_r, pix_g, pix_b}, 0);
    chk("rst_pos", {pos_x, pos_y}, 0);
    chk("rst_meas", {line_width, line_total, frame_height}, 0);
    chk("rst_flags", {frame_start, locked, timing_err}, 0);

    @(negedge clk);
    rst = 0;
    vw = 21'h000040;
    @(negedge clk);
    vw = 21'h100000;
    @(negedge clk);
    vw = '0;
    #1;
    chk("bit6_pix", {pix_r, pix_g, pix_b}, {6'd1, 6'd0, 6'd0});
    chk("bit6_sync", {pix_hs, pix_vs, pix_de}, 0);
    @(negedge clk);
    #1;
    chk("bit20_pix", {pix_r, pix_g, pix_b}, {6'd0, 6'd0, 6'd4});
    chk("bit20_rest", {pix_hs, pix_vs, pix_de, pos_x, pos_y, frame_start, locked, timing_err}, 0);
    chk("bit20_meas", {line_width, line_total, frame_height}, 0);

    rst = 1;
    repeat (2) @(negedge clk);
    base = fs_cnt;
    rst = 0;
    vw = mk(0, NV, -1);
    drive(NV, -1, 1, FL);
    drive(NV, -1, 0, FL);
    drive(NV, -1, 0, FL);
    chk("unlocked_3rd_vs", locked, 0);
    drive(NV, -1, 0, FL);
    #1;
    chk("lock_at_4th_vs", lock_fs, base + 4);
    chk("locked", locked, 1);
    chk("line_width", line_width, W);
    chk("line_total", line_total, T);
    chk("frame_height", frame_height, H);

    drive(NV, -1, 0, FL);
    #1;
    chk("first_pixel_pos", {first_x, first_y}, 0);
    chk("last_pixel_pos", {done_x, done_y}, {11'(W - 1), 11'(H - 1)});
    chk("vs_pos_y", fs_pos_y, 0);

    fs_pos_y = '1;
    drive(CV, -1, 0, FL);
    #1;
    chk("coinc_height", frame_height, H);
    chk("coinc_pos_y", fs_pos_y, 0);
    chk("coinc_last_pos", {done_x, done_y}, {11'(W - 1), 11'(H - 1)});
    chk("coinc_no_err", {locked, 32'(err_cnt)}, {1'b1, 32'd0});

    drive(NV, 3, 0, FL);
    #1;
    chk("short_err_pulse", err_cnt, 1);
    chk("short_unlock", err_locked, 0);
    chk("short_width", line_width, W);
    drive(NV, -1, 0, FL);
    drive(NV, -1, 0, FL);
    drive(NV, -1, 0, FL);
    #1;
    chk("relock_4th_vs", lock_fs, err_fs + 4);
    chk("relocked", locked, 1);
    chk("single_err", err_cnt, 1);

    drive(NV, -1, 0, 3 * T + 5);
    #2;
    rst = 1;
    #1;
    chk("midrst_sync", {pix_hs, pix_vs, pix_de}, 3'b110);
    chk("midrst_pix", {pix_r, pix_g, pix_b, pos_x, pos_y}, 0);
    chk("midrst_meas", {line_width, line_total, frame_height}, 0);
    chk("midrst_flags", {frame_start, locked, timing_err}, 0);
    base = fs_cnt;
    @(negedge clk);
    rst = 0;
    vw = mk(3 * T + 5, NV, -1);
    drive(NV, -1, 3 * T + 6, FL);
    drive(NV, -1, 0, FL);
    drive(NV, -1, 0, FL);
    chk("midrst_not_yet", locked, 0);
    drive(NV, -1, 0, FL);
    #1;
    chk("midrst_relock", lock_fs, base + 4);
    chk("midrst_meas_after", {line_width, line_total, frame_height}, {11'(W), 11'(T), 11'(H)});
    chk("midrst_no_err", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
